// File: rtl/serial_to_parallel_pkg.sv
// Purpose : shared constants and state encoding for the serial_to_parallel deserializer.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: s2p_state_e state enum, S2P_COMMA idle character, S2P_LOCK_COUNT_DEF default lock depth.
package s2p_pkg;

  typedef enum logic [1:0] {
    S2P_SEARCH  = 2'd0,
    S2P_LOCKING = 2'd1,
    S2P_ACTIVE  = 2'd2
  } s2p_state_e;

  localparam logic [7:0] S2P_COMMA          = 8'hBC;
  localparam int         S2P_LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Purpose : bundles the serial line and the recovered-byte outputs of serial_to_parallel.
// Latency : n/a (wiring only).
// Backpressure: none; the receiver cannot stall the line, bytes are presented as they arrive.
// Signals : data_in (serial, MSB first), data_out[7:0], valid_out, byte_strobe, active,
//           idle_count[7:0] only when S2P_IDLE_CNT_EN is defined.
//           master = line driver / byte consumer side, slave = deserializer side.
interface serial_to_parallel_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
`ifdef S2P_IDLE_CNT_EN
  logic [7:0] idle_count;

  modport master (output data_in, input data_out, valid_out, byte_strobe, active, idle_count);
  modport slave  (input data_in, output data_out, valid_out, byte_strobe, active, idle_count);
`else
  modport master (output data_in, input data_out, valid_out, byte_strobe, active);
  modport slave  (input data_in, output data_out, valid_out, byte_strobe, active);
`endif

endinterface

// File: rtl/serial_to_parallel_shifter.sv
// Purpose : serial shift register, 8-bit sampling window and byte-boundary counter.
// Latency : window is combinational on data_i; boundary_o is true on the edge that samples a byte LSB.
// Backpressure: none; one bit is consumed on every clk_32f edge.
// Ports   : clk_32f, reset (async active-low), data_i (serial bit), realign_i (restart byte count),
//           win_o[7:0] (seven stored bits plus the bit being sampled), boundary_o.
module s2p_shifter (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_i,
  input  logic       realign_i,
  output logic [7:0] win_o,
  output logic       boundary_o
);

  // Only seven stored bits are ever read; the oldest falls out of the window.
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  assign win_o      = {shift_q, data_i};
  assign boundary_o = (bit_cnt_q == 3'd7);

  always_comb begin
    shift_d   = {shift_q[5:0], data_i};
    // Realign zeroes the count on the comma's LSB edge so the next
    // boundary lands exactly eight edges later.
    bit_cnt_d = realign_i ? 3'd0 : bit_cnt_q + 3'd1;
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Purpose : byte-link receive deserializer; aligns on comma 8'hBC, locks after LOCK_COUNT commas.
// Latency : outputs update on the same edge that samples a byte's LSB; one byte every 8 clk_32f.
// Backpressure: none; byte_strobe pulses regardless of the consumer, which must keep up.
// Ports   : clk_32f, reset (async active-low), bus (serial_to_parallel_if.slave).
// Option  : S2P_IDLE_CNT_EN adds a saturating count of idle commas seen while ACTIVE (bus.idle_count).
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int LOCK_COUNT = S2P_LOCK_COUNT_DEF
) (
  input  logic           clk_32f,
  input  logic           reset,
  serial_to_parallel_if.slave bus
);

  localparam logic [1:0] ST_SEARCH  = S2P_SEARCH;
  localparam logic [1:0] ST_LOCKING = S2P_LOCKING;
  localparam logic [1:0] ST_ACTIVE  = S2P_ACTIVE;
  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);

  logic [7:0] win;
  logic       boundary;
  logic       realign;
  logic       is_comma;

  logic [1:0] state_q, state_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_out_q, data_out_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;

  s2p_shifter u_shifter (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_i     (bus.data_in),
    .realign_i  (realign),
    .win_o      (win),
    .boundary_o (boundary)
  );

  assign is_comma = (win == S2P_COMMA);

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    data_out_d  = data_out_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    realign     = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        // Hunt bit by bit; the byte counter is meaningless until a comma is seen.
        if (is_comma) begin
          realign     = 1'b1;
          comma_cnt_d = 4'd1;
          state_d     = (LOCK_CNT == 4'd1) ? ST_ACTIVE : ST_LOCKING;
        end
      end
      ST_LOCKING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == LOCK_CNT) state_d = ST_ACTIVE;
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = ST_SEARCH;
          end
        end
      end
      ST_ACTIVE: begin
        // Lock is sticky: only reset leaves ACTIVE.
        if (boundary) begin
          data_out_d = win;
          valid_d    = !is_comma;
          strobe_d   = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SEARCH;
      comma_cnt_q <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_q;
  assign bus.byte_strobe = strobe_q;
  assign bus.active      = (state_q == ST_ACTIVE);

`ifdef S2P_IDLE_CNT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q == ST_ACTIVE) && boundary && is_comma && (idle_cnt_q != 8'hFF))
      idle_cnt_d = idle_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end

  assign bus.idle_count = idle_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Purpose : self-checking bench for serial_to_parallel (lock, misalignment, failed lock, idle, reset).
// Latency : expects outputs on the LSB edge and a strobe every 8 cycles once locked.
// Backpressure: n/a; bytes are pushed to a scoreboard when driven and popped on byte_strobe.
module tb_serial_to_parallel;
  import s2p_pkg::*;

  logic clk_32f = 1'b0;
  logic reset   = 1'b0;

  serial_to_parallel_if s2p_bus ();

  serial_to_parallel #(.LOCK_COUNT(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (s2p_bus)
  );

  always #5 clk_32f = ~clk_32f;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  logic [8:0]  sb_q[$];   // {valid, data}
  logic [8:0]  sb_e;
  bit          have_last = 1'b0;
  int unsigned last_cyc  = 0;
  logic        act_prev  = 1'b0;

  always @(posedge clk_32f) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop the scoreboard on each strobe and check the strobe cadence.
  always @(negedge clk_32f) begin
    if (s2p_bus.byte_strobe === 1'b1) begin
      check("strobe_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("data_out", 32'(s2p_bus.data_out), 32'(sb_e[7:0]));
        check("valid_out", 32'(s2p_bus.valid_out), 32'(sb_e[8]));
      end
      if (have_last) check("strobe_period", cyc - last_cyc, 32'd8);
      last_cyc  = cyc;
      have_last = 1'b1;
    end
    if (s2p_bus.active === 1'b1 && act_prev !== 1'b1) begin
      // Lock edge: first strobe must follow exactly 8 cycles later.
      last_cyc  = cyc;
      have_last = 1'b1;
    end
    if (s2p_bus.active !== 1'b1) have_last = 1'b0;
    act_prev = s2p_bus.active;
  end

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      s2p_bus.data_in = b[i];
      @(posedge clk_32f);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_act, input logic exp_out);
    if (exp_out) sb_q.push_back({(b != S2P_COMMA), b});
    send_bits(b, 8);
    check("active", 32'(s2p_bus.active), 32'(exp_act));
    if (exp_out) check("byte_strobe_on_lsb", 32'(s2p_bus.byte_strobe), 32'd1);
  endtask

  task automatic do_reset();
    repeat (2) @(posedge clk_32f);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    s2p_bus.data_in = 1'b0;
    reset = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_32f);
    #1;
  endtask

  initial begin
    s2p_bus.data_in = 1'b0;
    repeat (3) @(posedge clk_32f);
    #1;
    check("rst_data_out", 32'(s2p_bus.data_out), 32'h00);
    check("rst_valid_out", 32'(s2p_bus.valid_out), 32'd0);
    check("rst_byte_strobe", 32'(s2p_bus.byte_strobe), 32'd0);
    check("rst_active", 32'(s2p_bus.active), 32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk_32f);
    #1;

    // Clean lock, then data
    for (int i = 0; i < 4; i++) send_byte(8'hBC, (i == 3), 1'b0);
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'hEE, 1'b1, 1'b1);

    // Idle comma in ACTIVE
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'hBC, 1'b1, 1'b1);
    send_byte(8'h02, 1'b1, 1'b1);

    // Reset mid-byte: outputs clear asynchronously
    send_bits(8'h77, 4);
    reset = 1'b0;
    s2p_bus.data_in = 1'b0;
    #2;
    check("midrst_data_out", 32'(s2p_bus.data_out), 32'h00);
    check("midrst_valid_out", 32'(s2p_bus.valid_out), 32'd0);
    check("midrst_byte_strobe", 32'(s2p_bus.byte_strobe), 32'd0);
    check("midrst_active", 32'(s2p_bus.active), 32'd0);
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_32f);
    #1;
    for (int i = 0; i < 4; i++) send_byte(8'hBC, (i == 3), 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1);
    do_reset();

    // Misaligned start: 3 stray bits, 5 commas, A5
    send_bits(8'b0100_0000, 3);
    for (int i = 0; i < 4; i++) send_byte(8'hBC, (i == 3), 1'b0);
    send_byte(8'hBC, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1);
    do_reset();

    // Failed lock: BC BC 55 drops back to search, then relock
    send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'hBC, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'hBC, (i == 3), 1'b0);
    send_byte(8'h12, 1'b1, 1'b1);

`ifdef S2P_IDLE_CNT_EN
    check("idle_cnt_start", 32'(s2p_bus.idle_count), 32'd0);
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hBC, 1'b1, 1'b1);
      if (i == 9) check("idle_cnt_10", 32'(s2p_bus.idle_count), 32'd10);
    end
    check("idle_cnt_sat", 32'(s2p_bus.idle_count), 32'hFF);
    do_reset();
    check("idle_cnt_rst", 32'(s2p_bus.idle_count), 32'd0);
`else
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Receive-side deserializer for the byte link whose transmit side is the parallel-to-serial converter. It samples the serial line on `clk_32f` and finds the byte boundary by searching for the idle comma `8'hBC`. After a run of aligned commas it locks and presents recovered bytes on an 8-bit bus. Comma bytes mark idle and are flagged not-valid. It sits at the receiving end of the link, feeding the downstream parallel domain.

## Interface
- `COMMA`, `8'hBC`, idle/alignment character the transmitter sends while its `valid_in` is low.
- `LOCK_COUNT`, `4`, consecutive aligned commas required to enter ACTIVE; legal range 1..15.
- `clk_32f`  in  1  single bit-rate clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial line, MSB first, one bit per `clk_32f` cycle.
- `data_out`  out  8  last recovered byte.
- `valid_out`  out  1  high when `data_out` holds a non-comma byte received while ACTIVE.
- `byte_strobe`  out  1  one-cycle pulse each time `data_out`/`valid_out` update.
- `active`  out  1  high while the state is ACTIVE.

## Operation
- **Shift path:**
  - Each edge: `shift <= {shift[6:0], data_in}`.
  - Window `win = {shift[6:0], data_in}`.
  - 3-bit counter `bit_cnt` marks the boundary when `bit_cnt==7`; it wraps 7→0.
- **SEARCH** (reset state):
  - `bit_cnt` is ignored.
  - Every edge, if `win==COMMA`: set `bit_cnt<=0`, `comma_cnt<=1`, go to LOCKING. If `LOCK_COUNT==1`, go directly to ACTIVE.
- **LOCKING:**
  - At each boundary, if `win==COMMA`: `comma_cnt++`. When it reaches `LOCK_COUNT`, go to ACTIVE.
  - At a boundary with `win!=COMMA`: `comma_cnt<=0`, return to SEARCH.
  - No output updates in this state.
- **ACTIVE:**
  - At each boundary: `data_out<=win`, `valid_out<=(win!=COMMA)`, `byte_strobe<=1`.
  - ACTIVE is left only by reset. No loss-of-lock detection.
- Outputs hold their values between boundaries. `byte_strobe` is 0 off-boundary.
- Reset (asserted at any time, including mid-byte): state SEARCH, `shift`/`bit_cnt`/`comma_cnt` = 0, and every output = 0. The partial byte is discarded.

## Timing
- Reset values: `data_out=8'h00`, `valid_out=0`, `byte_strobe=0`, `active=0`.
- Latency: the LSB of a byte is sampled at edge N, and `data_out`, `valid_out` and `byte_strobe` are updated by that same edge N. They are visible from N until N+1.
- Lock: `active` rises on the edge that samples the LSB of the `LOCK_COUNT`-th comma. The commas that lock produce no strobe.
- The first strobe after lock comes 8 edges later.
- Strobe period in ACTIVE: exactly 8 `clk_32f` cycles, no gaps.
- `data_in` must be stable around the rising edge of `clk_32f`. There is no internal synchronizer.

## Configuration
- `S2P_IDLE_CNT_EN`:
  - **Defined:** adds output `idle_count` (out, 8 bits). It increments on every ACTIVE-boundary comma, saturates at `8'hFF`, and resets to 0.
  - **Undefined:** neither the port nor the counter exists, and behaviour is otherwise identical.

## Structure
- Package `s2p_pkg`:
  - state enum `{S2P_SEARCH, S2P_LOCKING, S2P_ACTIVE}`
  - `S2P_COMMA = 8'hBC`
  - `S2P_LOCK_COUNT_DEF = 4`
- One sub-module, `s2p_shifter`. It holds the shift register, the window and `bit_cnt`, with a boundary flag and a `realign` input. The state machine and output registers live in the top module.

## Test plan
- **Clean lock:** after reset release, send 4×`BC` aligned, then `FF`, `EE`. Expect `active` to rise at the LSB of the 4th `BC`. Then strobes with `data_out=FF`, `valid_out=1`, then `data_out=EE`, `valid_out=1`, 8 cycles apart.
- **Misaligned start:** send 3 random bits, then 5×`BC` and `A5`. Expect alignment on the first `BC`, `active` after the 4th, a strobe with `BC`/`valid_out=0`, then `A5`/`valid_out=1`.
- **Failed lock:** send `BC`, `BC`, `55`, `BC`×4, `12`. Expect a return to SEARCH at `55` with `active=0`. Then lock on the following commas and `data_out=12` valid.
- **Idle in ACTIVE:** once locked, send `01`, `BC`, `02`. Expect strobes with valid 1/0/1 and `data_out` `01`/`BC`/`02`.
- **Reset mid-byte:** assert `reset` at bit 4 of a byte while ACTIVE. Expect all outputs at 0 asynchronously, state SEARCH. After release, relock only after 4 commas.
- **With `S2P_IDLE_CNT_EN`:** after lock, send 300 `BC`. Expect `idle_count` to saturate at `FF`. Reset returns it to 0.
